// File: rtl/fir_mem_responder_pkg.sv
// rtl/fir_mem_responder_pkg.sv - shared types and constants for the FIR bus memory
package fir_mem_responder_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

endpackage

// File: rtl/fir_mem_wait_fsm.sv
// rtl/fir_mem_wait_fsm.sv - per-port IDLE/WAIT/ACK handshake with programmable wait states
module fir_mem_wait_fsm
   import fir_mem_responder_pkg::*;
#(
   parameter int WAIT = 0
) (
   input  logic iClk,
   input  logic iRstn,
   input  logic iReq,
   output logic oWait,
   output logic oFetch,
   output logic oCommit,
   output logic oAbort
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // state and wait counter registers
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state; fetch on the edge leaving WAIT, commit on the edge leaving ACK
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oFetch  = 1'b0;
      oCommit = 1'b0;
      oAbort  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iReq) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(WAIT);
            end
         end
         ST_WAIT: begin
            if (!iReq) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               oAbort  = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_ACK;
               oFetch  = 1'b1;
            end
         end
         ST_ACK: begin
            oCommit = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign oWait = iReq && (state_q != ST_ACK);

endmodule

// File: rtl/fir_mem_responder.sv
// rtl/fir_mem_responder.sv - dual-port Avalon-MM slave RAM with wait states, preload and error flag
module fir_mem_responder
   import fir_mem_responder_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = 8,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 0
) (
   input  logic              iClk,
   input  logic              iRstn,
   input  logic [31:0]       iAddress_Slave_Read,
   input  logic              iRead_Slave_Read,
   output logic [DATA_W-1:0] oReadData_Slave_Read,
   output logic              oWait_Slave_Read,
   input  logic [31:0]       iAddress_Slave_Write,
   input  logic              iWrite_Slave_Write,
   input  logic [DATA_W-1:0] iWriteData_Slave_Write,
   output logic              oWait_Slave_Write,
   input  logic              iLoad_En,
   input  logic [ADDR_W-1:0] iLoad_Addr,
   input  logic [DATA_W-1:0] iLoad_Data,
   output logic              oProtoErr
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              rd_fetch, rd_ack, rd_abort;
   logic              wr_fetch, wr_commit, wr_abort;

   logic              rd_busy_q, rd_busy_d;
   logic              wr_busy_q, wr_busy_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              proto_err_q, proto_err_d;

   // upper address bits alias onto the RAM; they are intentionally ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{iAddress_Slave_Read[31:ADDR_W], iAddress_Slave_Write[31:ADDR_W],
                               rd_ack, wr_fetch};

   fir_mem_wait_fsm #(.WAIT(READ_WAIT)) u_rd_fsm (
      .iClk    (iClk),
      .iRstn   (iRstn),
      .iReq    (iRead_Slave_Read),
      .oWait   (oWait_Slave_Read),
      .oFetch  (rd_fetch),
      .oCommit (rd_ack),
      .oAbort  (rd_abort)
   );

   fir_mem_wait_fsm #(.WAIT(WRITE_WAIT)) u_wr_fsm (
      .iClk    (iClk),
      .iRstn   (iRstn),
      .iReq    (iWrite_Slave_Write),
      .oWait   (oWait_Slave_Write),
      .oFetch  (wr_fetch),
      .oCommit (wr_commit),
      .oAbort  (wr_abort)
   );

   // latch address/data when a port leaves IDLE; forward same-edge preload/commit into the read
   always_comb begin
      rd_busy_d   = rd_busy_q ? !(rd_abort || rd_ack) : iRead_Slave_Read;
      wr_busy_d   = wr_busy_q ? !(wr_abort || wr_commit) : iWrite_Slave_Write;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      wr_data_d   = wr_data_q;
      rd_data_d   = rd_data_q;
      proto_err_d = proto_err_q || rd_abort || wr_abort;
      if (!rd_busy_q && iRead_Slave_Read) begin
         rd_idx_d = iAddress_Slave_Read[ADDR_W-1:0];
      end
      if (!wr_busy_q && iWrite_Slave_Write) begin
         wr_idx_d  = iAddress_Slave_Write[ADDR_W-1:0];
         wr_data_d = iWriteData_Slave_Write;
      end
      if (rd_fetch) begin
         if (iLoad_En && (iLoad_Addr == rd_idx_q)) begin
            rd_data_d = iLoad_Data;
         end else if (wr_commit && (wr_idx_q == rd_idx_q)) begin
            rd_data_d = wr_data_q;
         end else begin
            rd_data_d = mem[rd_idx_q];
         end
      end
   end

   // control and datapath registers
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         rd_busy_q   <= 1'b0;
         wr_busy_q   <= 1'b0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         wr_data_q   <= '0;
         rd_data_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rd_busy_q   <= rd_busy_d;
         wr_busy_q   <= wr_busy_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         wr_data_q   <= wr_data_d;
         rd_data_q   <= rd_data_d;
         proto_err_q <= proto_err_d;
      end
   end

   // RAM array, not reset; preload is written last so it wins a same-index collision
   always_ff @(posedge iClk) begin
      if (wr_commit && iRstn) begin
         mem[wr_idx_q] <= wr_data_q;
      end
      if (iLoad_En) begin
         mem[iLoad_Addr] <= iLoad_Data;
      end
   end

   assign oReadData_Slave_Read = rd_data_q;
   assign oProtoErr            = proto_err_q;

endmodule
